// File: rtl/femto_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package femto_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    // Byte-to-word address shift for the 32-bit memory.
    localparam int unsigned MEM_ADDR_LSB = 2;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; raises force_if once the limit is reached.
module arb_starve_ctr #(
    parameter int unsigned IF_STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam int unsigned CNT_W = $clog2(IF_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port synchronous memory.
// Define MEM_ARB_PERF_EN to add the perf_conflicts / perf_if_stalls counters.
module unified_mem_arbiter
    import femto_pkg::*;
#(
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned IF_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_if_stalls,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   force_if;
    logic   dm_misaligned;
    logic   dm_err_q, dm_err_d;
    owner_t owner_q, owner_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+MEM_ADDR_LSB], if_addr[MEM_ADDR_LSB-1:0],
                                dm_addr[31:ADDR_W+MEM_ADDR_LSB]};

    arb_starve_ctr #(
        .IF_STARVE_MAX(IF_STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .force_if(force_if)
    );

    assign dm_misaligned = (dm_addr[MEM_ADDR_LSB-1:0] != '0);

    // Grants are held off while reset is asserted so nothing reaches memory.
    always_comb begin
        dm_gnt    = reset & dm_req & ~force_if;
        if_gnt    = reset & if_req & ~dm_gnt;
        mem_en    = if_gnt | (dm_gnt & ~dm_misaligned);
        mem_we    = dm_gnt & dm_we & ~dm_misaligned;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr[ADDR_W+MEM_ADDR_LSB-1:MEM_ADDR_LSB];
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr[ADDR_W+MEM_ADDR_LSB-1:MEM_ADDR_LSB];
        end
    end

    always_comb begin
        owner_d  = OWN_NONE;
        dm_err_d = 1'b0;
        if (dm_gnt && !dm_we) begin
            owner_d  = OWN_DM;
            dm_err_d = dm_misaligned;
        end else if (if_gnt) begin
            owner_d  = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q  <= OWN_NONE;
            dm_err_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            dm_err_q <= dm_err_d;
        end
    end

    always_comb begin
        if_rvalid = (owner_q == OWN_IF);
        dm_rvalid = (owner_q == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !dm_err_q) ? mem_rdata : '0;
        // Misaligned loads answer a cycle later; misaligned stores answer at grant.
        dm_err    = (dm_rvalid & dm_err_q) | (dm_gnt & dm_we & dm_misaligned);
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflicts_q, if_stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflicts_q <= '0;
            if_stalls_q <= '0;
        end else begin
            if (if_req && dm_req && conflicts_q != '1) begin
                conflicts_q <= conflicts_q + 1'b1;
            end
            if (if_req && !if_gnt && if_stalls_q != '1) begin
                if_stalls_q <= if_stalls_q + 1'b1;
            end
        end
    end

    assign perf_conflicts = conflicts_q;
    assign perf_if_stalls = if_stalls_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a behavioural single-port memory.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_if_stalls;
    logic [31:0] snap_conf, snap_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] exp_mem [64];
    logic [31:0] if_q [$];
    logic [32:0] dm_q [$];

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .dm_err   (dm_err),
`ifdef MEM_ARB_PERF_EN
        .perf_conflicts(perf_conflicts),
        .perf_if_stalls(perf_if_stalls),
`endif
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    initial begin
        mem_rdata <= '0;
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) chk("if_unexpected_rvalid", 1, 0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_rvalid) begin
                if (dm_q.size() == 0) begin
                    chk("dm_unexpected_rvalid", 1, 0);
                end else begin
                    logic [32:0] e;
                    e = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, e[31:0]);
                    chk("dm_err", 32'(dm_err), 32'(e[32]));
                end
            end
        end
    end

    // Drive one cycle at posedge+1, check grants at negedge, queue expected read responses.
    task automatic step(input string name, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dw, input logic e_ig, input logic e_dg,
                        input logic e_en, input logic [5:0] e_addr);
        logic mis;
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dw;
        @(negedge clk);
        chk({name, ".if_gnt"}, 32'(if_gnt), 32'(e_ig));
        chk({name, ".dm_gnt"}, 32'(dm_gnt), 32'(e_dg));
        chk({name, ".mem_en"}, 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk({name, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
            chk({name, ".mem_we"}, 32'(mem_we), 32'(e_dg & dwe));
        end
        if (e_ig) if_q.push_back(exp_mem[ia[7:2]]);
        if (e_dg) begin
            mis = (da[1:0] != 2'b00);
            if (dwe) begin
                chk({name, ".store_err"}, 32'(dm_err), 32'(mis));
                if (!mis) exp_mem[da[7:2]] = dw;
            end else begin
                dm_q.push_back({mis, mis ? 32'h0 : exp_mem[da[7:2]]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        step(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h20; dm_wdata = 32'h1234_5678;

        // Reset state: requests present but nothing granted or valid.
        @(negedge clk);
        chk("rst.if_gnt", 32'(if_gnt), 0);
        chk("rst.dm_gnt", 32'(dm_gnt), 0);
        chk("rst.mem_en", 32'(mem_en), 0);
        chk("rst.mem_we", 32'(mem_we), 0);
        chk("rst.if_rvalid", 32'(if_rvalid), 0);
        chk("rst.dm_rvalid", 32'(dm_rvalid), 0);
        chk("rst.dm_err", 32'(dm_err), 0);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Fetch only: byte 0x10 -> word 4.
        step("fetch10", 1, 32'h10, 0, 0, 0, 0, 1, 0, 1, 6'd4);
        idle("fetch10_rsp");

        // Reset asserted while a fetch read is outstanding.
        step("rstmid", 1, 32'h14, 0, 0, 0, 0, 1, 0, 1, 6'd5);
        reset = 1'b0;
        if_q.delete();
        @(negedge clk);
        chk("rstmid.if_rvalid", 32'(if_rvalid), 0);
        chk("rstmid.if_rdata", if_rdata, 0);
        chk("rstmid.if_gnt", 32'(if_gnt), 0);
        chk("rstmid.mem_en", 32'(mem_en), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("rstmid.no_rvalid", 32'(if_rvalid), 0);
        @(posedge clk); #1;

        // Both request: data load wins, fetch served next cycle.
        step("both", 1, 32'h30, 1, 0, 32'h20, 0, 0, 1, 1, 6'd8);
        step("fetch30", 1, 32'h30, 0, 0, 0, 0, 1, 0, 1, 6'd12);

        // Starvation: four denials, forced fetch, then data wins with counter cleared.
`ifdef MEM_ARB_PERF_EN
        snap_conf = perf_conflicts; snap_stall = perf_if_stalls;
`endif
        for (int k = 0; k < 4; k++) begin
            step("starve_dm", 1, 32'h04, 1, 0, 32'h40 + 32'(4 * k), 0, 0, 1, 1, 6'(16 + k));
        end
        step("starve_force", 1, 32'h04, 1, 0, 32'h50, 0, 1, 0, 1, 6'd1);
`ifdef MEM_ARB_PERF_EN
        chk("perf_if_stalls", perf_if_stalls - snap_stall, 4);
        chk("perf_conflicts", perf_conflicts - snap_conf, 5);
`endif
        step("starve_after", 1, 32'h08, 1, 0, 32'h50, 0, 0, 1, 1, 6'd20);
        step("starve_fetch", 1, 32'h08, 0, 0, 0, 0, 1, 0, 1, 6'd2);

        // Store then fetch back the same word.
        step("store0c", 0, 0, 1, 1, 32'h0C, 32'hDEAD_BEEF, 0, 1, 1, 6'd3);
        step("fetch0c", 1, 32'h0C, 0, 0, 0, 0, 1, 0, 1, 6'd3);
        idle("fetch0c_rsp");
        chk("store0c.model", exp_mem[3], 32'hDEAD_BEEF);

        // Misaligned load and store; memory untouched.
        step("misld22", 0, 0, 1, 0, 32'h22, 0, 0, 1, 0, 6'd0);
        step("misst26", 0, 0, 1, 1, 32'h26, 32'hFFFF_FFFF, 0, 1, 0, 6'd0);
        step("fetch24", 1, 32'h24, 0, 0, 0, 0, 1, 0, 1, 6'd9);

        // Upper address bits wrap modulo memory size.
        step("wrap104", 1, 32'h104, 0, 0, 0, 0, 1, 0, 1, 6'd1);
        step("wrapld", 0, 0, 1, 0, 32'h0000_1028, 0, 0, 1, 1, 6'd10);
        idle("drain0");
        idle("drain1");

        chk("if_q_empty", 32'(if_q.size()), 0);
        chk("dm_q_empty", 32'(dm_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
